seg7_scan_capture: RTL and testbench

- Receive end of the multiplexed 7-segment display interface: monitors the scanned `seg7`/`seg7_sel` bus driven by the display scanner (`seg7_select` + `bcd_to_seg7_1`).
- Reconstructs per-digit BCD values, flags illegal patterns and scan positions, and reports complete and stable frames.
- Sits beside the traffic controller top as a self-check / readback monitor; all inputs are synchronous to `clk`.

---
 rtl/seg7_scan_capture.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// Readback monitor for the scanned 7-segment bus: settles each digit dwell,
// decodes it back to BCD, assembles frames and reports stable values.
// Optional build macro SEG7_ACTIVE_LOW_EN: treat the pattern as active-low
// (common-anode, 0 = lit) before compare and decode.
module seg7_scan_capture #(
  parameter int unsigned NUM_USE       = 2,
  parameter int unsigned SETTLE        = 2,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           seg7,
  input  logic [2:0]           seg7_sel,
  input  logic                 err_clr,
  output logic [4*NUM_USE-1:0] digits,
  output logic                 frame_stb,
  output logic [6:0]           value,
  output logic                 value_stb,
  output logic                 pat_err,
  output logic                 sel_err
);

  localparam int unsigned DW     = 4 * NUM_USE;
  localparam int unsigned CW     = 4;
  localparam int unsigned MW     = 3;
  localparam logic [2:0]  POS_HI = 3'd5;
  localparam logic [2:0]  POS_LO = 3'(6 - NUM_USE);

  logic [6:0]    s_q;
  logic [2:0]    p_q, p_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [NUM_USE-1:0] mask_q, mask_d;
  logic          have_q, have_d;
  logic [MW-1:0] match_q, match_d;
  logic [DW-1:0] digits_d;
  logic          frame_stb_d, value_stb_d, pat_err_d, sel_err_d;
  logic [6:0]    value_d;

  logic [6:0] s_eff;
  logic [3:0] nib;
  logic       bad, changed, capture, in_range, wrap, frame_done, eq, fire;
  logic [2:0] idx;
  logic [3:0] units, tens;

  assign units = dig_q[3:0];

  // Tens digit exists only when at least two positions are scanned
  if (NUM_USE > 1) begin : g_tens
    assign tens = dig_q[7:4];
  end else begin : g_no_tens
    assign tens = 4'd0;
  end

  // Inverse display table on the registered pattern
  always_comb begin
`ifdef SEG7_ACTIVE_LOW_EN
    s_eff = ~s_q;
`else
    s_eff = s_q;
`endif
    bad = 1'b0;
    nib = 4'hE;
    case (s_eff)
      7'b1111110: nib = 4'd0;
      7'b0110000: nib = 4'd1;
      7'b1101101: nib = 4'd2;
      7'b1111001: nib = 4'd3;
      7'b0110011: nib = 4'd4;
      7'b1011011: nib = 4'd5;
      7'b1011111: nib = 4'd6;
      7'b1110000: nib = 4'd7;
      7'b1111111: nib = 4'd8;
      7'b1111011: nib = 4'd9;
      7'b0000001: nib = 4'hF;
      default:    bad = 1'b1;
    endcase
  end

  // Settle tracking, capture into digit registers, frame assembly and stability
  always_comb begin
    changed  = (seg7 != s_q) || (seg7_sel != p_q);
    in_range = (p_q >= POS_LO) && (p_q <= POS_HI);
    idx      = 3'(POS_HI - p_q);
    capture  = (cnt_q == CW'(SETTLE)) && !done_q;
    wrap     = (p_q == POS_HI) && (p_prev_q == POS_LO) && (p_prev_q != p_q);

    cnt_d  = cnt_q;
    done_d = done_q | capture;
    if (changed) begin
      cnt_d  = CW'(1);
      done_d = 1'b0;
    end else if (cnt_q < CW'(SETTLE)) begin
      cnt_d = CW'(cnt_q + CW'(1));
    end

    // A capture on the wrap cycle lands in the new frame's mask
    dig_d  = dig_q;
    mask_d = wrap ? '0 : mask_q;
    if (capture && in_range) begin
      for (int k = 0; k < int'(NUM_USE); k++) begin
        if (idx == 3'(k)) begin
          dig_d[4*k +: 4] = nib;
          mask_d[k]       = 1'b1;
        end
      end
    end

    frame_done  = wrap && (&mask_q);
    eq          = have_q && (dig_q == digits);
    digits_d    = digits;
    have_d      = have_q;
    match_d     = match_q;
    frame_stb_d = frame_done;
    value_stb_d = 1'b0;
    value_d     = value;
    fire        = 1'b0;
    if (frame_done) begin
      digits_d = dig_q;
      have_d   = 1'b1;
      if (eq) begin
        if (match_q < MW'(STABLE_FRAMES)) match_d = MW'(match_q + MW'(1));
      end else begin
        match_d = MW'(1);
      end
      fire = (match_d == MW'(STABLE_FRAMES)) && !(eq && (match_q == MW'(STABLE_FRAMES)));
      if (fire && (tens <= 4'd9) && (units <= 4'd9)) begin
        value_d     = 7'(7'(tens) * 7'd10 + 7'(units));
        value_stb_d = 1'b1;
      end
    end

    pat_err_d = (pat_err && !err_clr) || (capture && in_range && bad);
    sel_err_d = (sel_err && !err_clr) || (capture && !in_range);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q       <= 7'd0;
      p_q       <= POS_HI;
      p_prev_q  <= POS_HI;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      dig_q     <= '0;
      mask_q    <= '0;
      have_q    <= 1'b0;
      match_q   <= '0;
      digits    <= '0;
      frame_stb <= 1'b0;
      value     <= 7'd0;
      value_stb <= 1'b0;
      pat_err   <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      s_q       <= seg7;
      p_q       <= seg7_sel;
      p_prev_q  <= p_q;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      dig_q     <= dig_d;
      mask_q    <= mask_d;
      have_q    <= have_d;
      match_q   <= match_d;
      digits    <= digits_d;
      frame_stb <= frame_stb_d;
      value     <= value_d;
      value_stb <= value_stb_d;
      pat_err   <= pat_err_d;
      sel_err   <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (default parameters, either polarity build).
module tb_seg7_scan_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg7;
  logic [2:0] seg7_sel;
  logic       err_clr;
  logic [7:0] digits;
  logic       frame_stb, value_stb, pat_err, sel_err;
  logic [6:0] value;

  int n_cmp = 0;
  int n_bad = 0;
  int frm_cnt = 0;
  int val_cnt = 0;
  logic [6:0] vals [0:3];

  localparam logic [6:0] ILLEGAL = 7'b1010101;

  seg7_scan_capture dut (
    .clk(clk), .reset(rst_n), .seg7(seg7), .seg7_sel(seg7_sel), .err_clr(err_clr),
    .digits(digits), .frame_stb(frame_stb), .value(value), .value_stb(value_stb),
    .pat_err(pat_err), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Count strobes away from the active edge
  always @(negedge clk) begin
    if (frame_stb) frm_cnt++;
    if (value_stb) begin
      if (val_cnt < 4) vals[val_cnt] = value;
      val_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  function automatic logic [6:0] pol(input logic [6:0] p);
`ifdef SEG7_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic dwell(input logic [6:0] pat, input logic [2:0] sel, input int n);
    seg7     = pol(pat);
    seg7_sel = sel;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_fstb"}, 32'(frame_stb), 32'h0);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_vstb"}, 32'(value_stb), 32'h0);
    check({tag, "_pat_err"}, 32'(pat_err), 32'h0);
    check({tag, "_sel_err"}, 32'(sel_err), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; seg7 = 7'd0; seg7_sel = 3'd5; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");

    // Three frames of "15"
    seg7 = pol(seg_of(5)); seg7_sel = 3'd5;
    rst_n = 1'b1;
    frm_cnt = 0; val_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      dwell(seg_of(5), 3'd5, 4);
      dwell(seg_of(1), 3'd4, 4);
    end
    dwell(seg_of(5), 3'd5, 4);
    check("t1_frames", 32'(frm_cnt), 32'd3);
    check("t1_vstb", 32'(val_cnt), 32'd1);
    check("t1_digits", 32'(digits), 32'h15);
    check("t1_value", 32'(value), 32'd15);

    // Too-short dwell at pos5 leaves the frame incomplete
    dwell(seg_of(1), 3'd4, 4);
    dwell(seg_of(8), 3'd5, 1);
    dwell(seg_of(1), 3'd4, 4);
    frm_cnt = 0; val_cnt = 0;
    dwell(seg_of(5), 3'd5, 4);
    dwell(seg_of(1), 3'd4, 4);
    check("t2_no_frame", 32'(frm_cnt), 32'd0);
    check("t2_digits", 32'(digits), 32'h15);

    // Undecodable pattern at pos5
    frm_cnt = 0; val_cnt = 0;
    dwell(ILLEGAL, 3'd5, 4);
    dwell(seg_of(1), 3'd4, 4);
    dwell(ILLEGAL, 3'd5, 4);
    dwell(seg_of(1), 3'd4, 4);
    dwell(ILLEGAL, 3'd5, 4);
    check("t3_frames", 32'(frm_cnt), 32'd3);
    check("t3_digits", 32'(digits), 32'h1E);
    check("t3_pat_err", 32'(pat_err), 32'd1);
    check("t3_no_vstb", 32'(val_cnt), 32'd0);
    check("t3_value_hold", 32'(value), 32'd15);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_pat_clr", 32'(pat_err), 32'd0);

    // Out-of-range position; clear collides with the set on the capture cycle
    frm_cnt = 0; val_cnt = 0;
    dwell(seg_of(1), 3'd4, 4);
    seg7 = pol(seg_of(8)); seg7_sel = 3'd3;
    @(negedge clk); @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    check("t4_sel_err", 32'(sel_err), 32'd1);
    dwell(seg_of(1), 3'd4, 4);
    check("t4_sel_err_hold", 32'(sel_err), 32'd1);
    check("t4_pat_err", 32'(pat_err), 32'd0);
    check("t4_digits", 32'(digits), 32'h1E);
    check("t4_no_frame", 32'(frm_cnt), 32'd0);

    // Frames 23, 23, 24, 24
    frm_cnt = 0; val_cnt = 0;
    dwell(seg_of(3), 3'd5, 4); dwell(seg_of(2), 3'd4, 4);
    dwell(seg_of(3), 3'd5, 4); dwell(seg_of(2), 3'd4, 4);
    dwell(seg_of(4), 3'd5, 4); dwell(seg_of(2), 3'd4, 4);
    dwell(seg_of(4), 3'd5, 4); dwell(seg_of(2), 3'd4, 4);
    dwell(seg_of(4), 3'd5, 4);
    check("t5_frames", 32'(frm_cnt), 32'd5);
    check("t5_vstb", 32'(val_cnt), 32'd2);
    check("t5_val0", 32'(vals[0]), 32'd23);
    check("t5_val1", 32'(vals[1]), 32'd24);
    check("t5_digits", 32'(digits), 32'h24);

    // Reset mid-dwell at pos4
    seg7 = pol(seg_of(2)); seg7_sel = 3'd4;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    frm_cnt = 0; val_cnt = 0;
    dwell(seg_of(2), 3'd4, 4);
    dwell(seg_of(5), 3'd5, 4);
    check("t6_partial", 32'(frm_cnt), 32'd0);
    dwell(seg_of(1), 3'd4, 4);
    dwell(seg_of(5), 3'd5, 4);
    check("t6_first", 32'(frm_cnt), 32'd1);
    check("t6_no_vstb", 32'(val_cnt), 32'd0);
    dwell(seg_of(1), 3'd4, 4);
    dwell(seg_of(5), 3'd5, 4);
    check("t6_vstb", 32'(val_cnt), 32'd1);
    check("t6_value", 32'(value), 32'd15);
    check("t6_digits", 32'(digits), 32'h15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
